// File: rtl/bus_map_pkg.sv
// ---------------------------------------------------------------------------
// bus_map_pkg
// Shared types and constants for the registered load/store memory-map decoder.
//   state_e       : decoder FSM states (IDLE, ACCESS, RESP, ERR)
//   *_BASE/*_LIMIT: default device windows (data, program, GPIO, UART)
//   clog2()       : index width helper, never returns less than 1
// ---------------------------------------------------------------------------
package bus_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_e;

    localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
    localparam logic [31:0] DMEM_LIMIT = 32'h1001_00FF;
    localparam logic [31:0] PMEM_BASE  = 32'h0040_0000;
    localparam logic [31:0] PMEM_LIMIT = 32'h0040_FFFF;
    localparam logic [31:0] GPIO_BASE  = 32'h1001_0100;
    localparam logic [31:0] GPIO_LIMIT = 32'h1001_0107;
    localparam logic [31:0] UART_BASE  = 32'h1001_0108;
    localparam logic [31:0] UART_LIMIT = 32'h1001_011F;

    // Width needed to index n items; a single item still gets one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_map_arbiter_ws_addr_window_match.sv
// ---------------------------------------------------------------------------
// addr_window_match
// Compares one address against a single inclusive [base, limit] window.
//   addr_i   : byte address from the master
//   base_i   : window base address
//   limit_i  : inclusive window upper bound
//   hit_o    : 1 when base_i <= addr_i <= limit_i (unsigned)
//   offset_o : word offset inside the window, (addr_i - base_i) >> 2
// ---------------------------------------------------------------------------
module addr_window_match
    import bus_map_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] offset_o
);

    logic [ADDR_W-1:0] diff;

    // Full-width subtraction; the offset is only meaningful when hit_o is set.
    assign diff     = addr_i - base_i;
    assign hit_o    = (addr_i >= base_i) && (addr_i <= limit_i);
    assign offset_o = {2'b00, diff[ADDR_W-1:2]};

endmodule

// File: rtl/bus_map_arbiter_ws.sv
// ---------------------------------------------------------------------------
// bus_map_arbiter_ws
// Registered memory-map decoder between the core load/store port and N_SLV
// memory-mapped devices, with per-slave wait states, read-only windows and
// a decode-error response.
// Optional feature: define BUS_TIMEOUT_EN to abort an ACCESS that waits
// TIMEOUT_CYC cycles without s_ready (answered with m_err=1).
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   m_req/m_we       : master request (sampled in IDLE only) / write flag
//   m_addr/m_wdata   : master byte address / write data
//   m_rdata          : read data, valid while m_ready=1
//   m_ready/m_err    : one-cycle completion strobe / error flag
//   s_sel            : one-hot slave select (all-zero when idle)
//   s_we             : write enable to the selected slave
//   s_addr/s_wdata   : word offset inside the window / write data
//   s_rdata/s_ready  : flattened slave read data / per-slave completion
// ---------------------------------------------------------------------------
module bus_map_arbiter_ws
    import bus_map_pkg::*;
#(
    parameter int                        N_SLV       = 4,
    parameter int                        ADDR_W      = 32,
    parameter int                        DATA_W      = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE    = {UART_BASE, GPIO_BASE, PMEM_BASE, DMEM_BASE},
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_LIMIT   = {UART_LIMIT, GPIO_LIMIT, PMEM_LIMIT, DMEM_LIMIT},
    parameter logic [N_SLV-1:0]          RO_MASK     = 4'b0010,
    parameter int                        TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_req,
    input  logic                    m_we,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_sel,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    input  logic [N_SLV-1:0]        s_ready
);

    localparam int IDX_W = clog2(N_SLV);

    // ------------------------------------------------------------ decode --
    logic [N_SLV-1:0]  win_hit;
    logic [ADDR_W-1:0] win_off [N_SLV];

    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_win
            addr_window_match #(
                .ADDR_W (ADDR_W)
            ) u_match (
                .addr_i   (m_addr),
                .base_i   (SLV_BASE[gi*ADDR_W +: ADDR_W]),
                .limit_i  (SLV_LIMIT[gi*ADDR_W +: ADDR_W]),
                .hit_o    (win_hit[gi]),
                .offset_o (win_off[gi])
            );
        end
    endgenerate

    logic              any_hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [N_SLV-1:0]  hit_onehot;
    logic [ADDR_W-1:0] hit_off;
    logic              ro_viol;

    // Priority encoder: scanning from the top down lets the lowest matching
    // index overwrite the others, so overlapping windows resolve to it.
    always_comb begin
        any_hit    = |win_hit;
        hit_idx    = '0;
        hit_onehot = '0;
        hit_off    = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                hit_idx       = IDX_W'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_off       = win_off[i];
            end
        end
        ro_viol = m_we && RO_MASK[hit_idx];
    end

    // ------------------------------------------------------------- state --
    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;
    logic [N_SLV-1:0]  sel_q;
    logic              swe_q;

    logic              cur_ready;
    logic [DATA_W-1:0] cur_rdata;

    // Only the latched slave is listened to; pulses from others are ignored.
    assign cur_ready = s_ready[idx_q];
    assign cur_rdata = s_rdata[int'(idx_q)*DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            swe_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            // Completion strobes are single-cycle by default.
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_req) begin
                        idx_q   <= hit_idx;
                        we_q    <= m_we;
                        off_q   <= hit_off;
                        wdata_q <= m_wdata;
                        if (!any_hit || ro_viol) begin
                            state_q <= ERR;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= ACCESS;
                            sel_q   <= hit_onehot;
                            swe_q   <= m_we;
`ifdef BUS_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (cur_ready) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= we_q ? '0 : cur_rdata;
                        sel_q   <= '0;
                        swe_q   <= 1'b0;
                    end
`ifdef BUS_TIMEOUT_EN
                    // A ready in the limit cycle is handled above and wins.
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= ERR;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        sel_q   <= '0;
                        swe_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_rdata = rdata_q;
    assign m_ready = ready_q;
    assign m_err   = err_q;
    assign s_sel   = sel_q;
    assign s_we    = swe_q;
    assign s_addr  = off_q;
    assign s_wdata = wdata_q;

endmodule

// File: tb/tb_bus_map_arbiter_ws.sv
// ---------------------------------------------------------------------------
// tb_bus_map_arbiter_ws
// Scoreboard bench for bus_map_arbiter_ws. The stimulus process decodes each
// request against the window table, pushes the expected response and the
// cycle it must appear in, and a separate monitor compares the slave-side
// and master-side outputs every cycle. A slave model answers with a
// per-transaction number of wait states and random noise on unselected
// s_ready lines.
// ---------------------------------------------------------------------------
module tb_bus_map_arbiter_ws;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m_req = 1'b0;
    logic         m_we = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [31:0]  m_wdata = '0;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_err;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata = '0;
    logic [3:0]   s_ready = '0;

    always #5 clk = ~clk;

    bus_map_arbiter_ws #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    // Device map: data, program (read-only), GPIO, UART.
    logic [31:0] wbase [4] = '{32'h1001_0000, 32'h0040_0000, 32'h1001_0100, 32'h1001_0108};
    logic [31:0] wlim  [4] = '{32'h1001_00FF, 32'h0040_FFFF, 32'h1001_0107, 32'h1001_011F};
    bit          wro   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] slv_data [4];

    typedef struct {
        int          k;      // cycle whose closing edge accepts the request
        int          lat;    // cycles from acceptance to the m_ready cycle
        bit          err;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic [31:0] saddr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_done = -10;
    int cur_wait  = 0;
    bit mon_en    = 1'b1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Slave model: the selected slave raises s_ready after cur_wait cycles.
    initial begin
        int acc;
        logic [3:0] nz;
        acc = 0;
        forever begin
            @(negedge clk);
            nz = 4'($urandom);
            if (s_sel != 4'b0) begin
                s_ready = (nz & ~s_sel) | ((acc == cur_wait) ? s_sel : 4'b0);
                acc++;
            end else begin
                s_ready = nz;
                acc = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                check("sel_onehot0", 32'($onehot0(s_sel)), 32'd1);
                check("we_without_sel", 32'(s_we && (s_sel == 4'b0)), 32'd0);
                if (sb.size() != 0 && cyc > sb[0].k) begin
                    e = sb[0];
                    if (cyc < e.k + e.lat) begin
                        check("access_ready", 32'(m_ready), 32'd0);
                        check("access_sel", 32'(s_sel), 32'(e.sel));
                        check("access_saddr", s_addr, e.saddr);
                        check("access_we", 32'(s_we), 32'(e.we));
                        check("access_wdata", s_wdata, e.wdata);
                    end else begin
                        check("resp_ready", 32'(m_ready), 32'd1);
                        check("resp_err", 32'(m_err), 32'(e.err));
                        check("resp_rdata", m_rdata, e.rdata);
                        check("resp_sel", 32'(s_sel), 32'd0);
                        $display("txn addr=%h we=%0d err=%0d rdata=%h lat=%0d", e.addr, e.we, m_err, m_rdata, e.lat);
                        void'(sb.pop_front());
                        last_done = cyc;
                    end
                end else begin
                    check("idle_ready", 32'(m_ready), 32'd0);
                    check("idle_sel", 32'(s_sel), 32'd0);
                end
            end
        end
    end

    // Issue one request, model the expected response, wait for completion.
    task automatic issue(input logic [31:0] addr, input bit we, input int wt, input logic [31:0] rd);
        exp_t e;
        int   hit;
        int   guard;
        hit = -1;
        for (int i = 0; i < 4; i++) begin
            if (hit < 0 && addr >= wbase[i] && addr <= wlim[i]) hit = i;
        end
        for (int i = 0; i < 4; i++) slv_data[i] = $urandom;
        if (hit >= 0) slv_data[hit] = rd;
        for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = slv_data[i];

        // Right after a response the decoder spends one cycle in IDLE first.
        e.k     = (cyc == last_done) ? cyc + 1 : cyc;
        e.addr  = addr;
        e.we    = we;
        e.wdata = $urandom;
        e.sel   = 4'b0;
        e.saddr = 32'b0;
        e.rdata = 32'b0;
        if (hit < 0 || (we && wro[hit])) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.sel   = 4'(1 << hit);
            e.saddr = (addr - wbase[hit]) >> 2;
            e.err   = 1'b0;
            e.lat   = 2 + wt;
            e.rdata = we ? 32'b0 : slv_data[hit];
`ifdef BUS_TIMEOUT_EN
            if (wt >= TO) begin
                e.err   = 1'b1;
                e.lat   = TO + 1;
                e.rdata = 32'b0;
            end
`endif
        end
        cur_wait = wt;
        m_req    = 1'b1;
        m_we     = we;
        m_addr   = addr;
        m_wdata  = e.wdata;
        sb.push_back(e);

        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
            // After acceptance, scramble the master inputs: they must be ignored.
            if (sb.size() != 0 && cyc > e.k) begin
                m_req   = 1'($urandom_range(0, 1));
                m_we    = 1'($urandom_range(0, 1));
                m_addr  = $urandom;
                m_wdata = $urandom;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: got no m_ready, expected one for addr %h", addr);
            sb.delete();
        end
        if ($urandom_range(0, 2) != 0) begin
            m_req = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    logic [31:0] d_addr [10] = '{32'h1001_0004, 32'h0040_0010, 32'h2000_0000, 32'h1001_0110,
                                 32'h0040_0010, 32'h1001_00FF, 32'h1001_0100, 32'h1001_011F,
                                 32'h1001_0120, 32'h003F_FFFF};
    bit          d_we   [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int          d_wait [10] = '{0, 0, 0, 3, 1, 2, 0, 4, 0, 0};

    initial begin
        logic [31:0] a;
        int          s;
        int          wt;
        int          hold;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 32'(m_ready), 32'd0);
        check("reset_err", 32'(m_err), 32'd0);
        check("reset_sel", 32'(s_sel), 32'd0);
        check("reset_we", 32'(s_we), 32'd0);
        check("reset_rdata", m_rdata, 32'd0);
        check("reset_saddr", s_addr, 32'd0);
        check("reset_swdata", s_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Directed cases, including window boundaries.
        issue(d_addr[0], d_we[0], d_wait[0], 32'hDEAD_BEEF);
        for (int i = 1; i < 10; i++) issue(d_addr[i], d_we[i], d_wait[i], $urandom);
        issue(32'h0040_FFFF, 1'b0, 1, $urandom);
`ifdef BUS_TIMEOUT_EN
        issue(32'h1001_0100, 1'b0, 1000, $urandom);
        issue(32'h1001_0104, 1'b0, TO - 1, $urandom);
`endif

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom;
            end else begin
                s = $urandom_range(0, 3);
                a = wbase[s] - 32'd8 + 32'($urandom_range(0, wlim[s] - wbase[s] + 32'd16));
            end
            wt = $urandom_range(0, 3);
`ifdef BUS_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) wt = $urandom_range(TO - 2, TO + 4);
`endif
            issue(a, 1'($urandom_range(0, 1)), wt, $urandom);
        end

        // Reset in the middle of an ACCESS to a slave that never answers.
        m_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        mon_en   = 1'b0;
        cur_wait = 1000;
        m_req    = 1'b1;
        m_we     = 1'b0;
        m_addr   = 32'h1001_0104;
        @(negedge clk);
        #1;
        m_req = 1'b0;
`ifdef BUS_TIMEOUT_EN
        hold = 8;
`else
        hold = 30;
`endif
        repeat (hold) @(negedge clk);
        #1;
        check("stuck_sel", 32'(s_sel), 32'h4);
        check("stuck_saddr", s_addr, 32'd1);
        check("stuck_ready", 32'(m_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(s_sel), 32'd0);
        check("async_rst_we", 32'(s_we), 32'd0);
        check("async_rst_ready", 32'(m_ready), 32'd0);
        check("async_rst_err", 32'(m_err), 32'd0);
        check("async_rst_rdata", m_rdata, 32'd0);
        check("async_rst_saddr", s_addr, 32'd0);
        check("async_rst_swdata", s_wdata, 32'd0);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        sb.delete();
        last_done = -10;
        mon_en    = 1'b1;
        issue(32'h1001_0000, 1'b0, 1, 32'h1234_5678);
        issue(32'h1001_0008, 1'b1, 0, $urandom);

        m_req = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
